// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pkg
//  Purpose  : Shared definitions for the seven-segment scan decoder and the
//             pattern decoder: segment bit positions, active-high glyph
//             encodings for hex digits 0-F and blank, and the frame-lock
//             state type.
//  Revision : 1.0  initial release
// ============================================================================
package seg7_pkg;

    // Bit position of each segment within a 7-bit segment vector.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F_BIT = 5;
    localparam int SEG_G = 6;

    // Active-high glyphs, bit 0 = a ... bit 6 = g.
    localparam logic [6:0] SEG_0     = 7'h3F;  // a b c d e f
    localparam logic [6:0] SEG_1     = 7'h06;  // b c
    localparam logic [6:0] SEG_2     = 7'h5B;  // a b d e g
    localparam logic [6:0] SEG_3     = 7'h4F;  // a b c d g
    localparam logic [6:0] SEG_4     = 7'h66;  // b c f g
    localparam logic [6:0] SEG_5     = 7'h6D;  // a c d f g
    localparam logic [6:0] SEG_6     = 7'h7D;  // a c d e f g
    localparam logic [6:0] SEG_7     = 7'h07;  // a b c
    localparam logic [6:0] SEG_8     = 7'h7F;  // all
    localparam logic [6:0] SEG_9     = 7'h6F;  // a b c d f g
    localparam logic [6:0] SEG_A_GLYPH = 7'h77;  // a b c e f g
    localparam logic [6:0] SEG_B_GLYPH = 7'h7C;  // c d e f g
    localparam logic [6:0] SEG_C_GLYPH = 7'h39;  // a d e f
    localparam logic [6:0] SEG_D_GLYPH = 7'h5E;  // b c d e g
    localparam logic [6:0] SEG_E_GLYPH = 7'h79;  // a d e f g
    localparam logic [6:0] SEG_F_GLYPH = 7'h71;  // a e f g
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Frame-lock state: IDLE = no valid frame, LOCKED = frame_valid high.
    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_pattern_decode
//  Purpose  : Combinational decode of an active-high 7-segment pattern back
//             to a hex nibble. Also used by the driver's self-test.
//  Ports    : seg_i    [6:0] active-high segments (bit 0 = a)
//             legal_o        pattern is a 0-F glyph or blank
//             blank_o        all segments off
//             nibble_o [3:0] decoded value (0 when blank or illegal)
//  Revision : 1.0  initial release
// ============================================================================
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       legal_o,
    output logic       blank_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        legal_o  = 1'b1;
        blank_o  = 1'b0;
        nibble_o = 4'h0;
        case (seg_i)
            SEG_0:       nibble_o = 4'h0;
            SEG_1:       nibble_o = 4'h1;
            SEG_2:       nibble_o = 4'h2;
            SEG_3:       nibble_o = 4'h3;
            SEG_4:       nibble_o = 4'h4;
            SEG_5:       nibble_o = 4'h5;
            SEG_6:       nibble_o = 4'h6;
            SEG_7:       nibble_o = 4'h7;
            SEG_8:       nibble_o = 4'h8;
            SEG_9:       nibble_o = 4'h9;
            SEG_A_GLYPH: nibble_o = 4'hA;
            SEG_B_GLYPH: nibble_o = 4'hB;
            SEG_C_GLYPH: nibble_o = 4'hC;
            SEG_D_GLYPH: nibble_o = 4'hD;
            SEG_E_GLYPH: nibble_o = 4'hE;
            SEG_F_GLYPH: nibble_o = 4'hF;
            SEG_BLANK:   blank_o  = 1'b1;
            default:     legal_o  = 1'b0;
        endcase
    end

endmodule : seg7_pattern_decode
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_decoder
//  Purpose  : Receive side of a 4-digit multiplexed seven-segment display.
//             Synchronizes the scan lines, waits for each digit to settle,
//             decodes the lit glyph and assembles complete 4-digit frames.
//  Ports    : clk_in           clock
//             RESET            asynchronous active-low reset
//             anode      [3:0] digit enables, anode[3] = leftmost digit
//             segs       [6:0] segment lines, segs[0] = a
//             digits    [15:0] last complete frame, digit i in [4i+3:4i]
//             blank      [3:0] per-digit "all segments off" flag
//             frame_valid      frame completed and no timeout since
//             frame_stb        one-cycle pulse when digits/blank update
//             code_err         one-cycle pulse per illegal sample
//             err_cnt    [7:0] saturating count of code_err pulses
//  Revision : 1.0  initial release
// ============================================================================
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic        clk_in,
    input  logic        RESET,
    input  logic [3:0]  anode,
    input  logic [6:0]  segs,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic        frame_valid,
    output logic        frame_stb,
    output logic        code_err,
    output logic [7:0]  err_cnt
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES);
    // Synchronizer reset value: all lines inactive, so the first sample
    // after reset is a harmless blanking interval.
    localparam logic [10:0]      RAW_IDLE = {11{ACTIVE_LOW}};

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    logic [10:0]      sync1_q, sync2_q;
    logic [CNT_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [3:0]       shadow_blank_q, shadow_blank_d;
    logic [3:0]       mask_q, mask_d;
    logic [15:0]      digits_q, digits_d;
    logic [3:0]       blank_q, blank_d;
    logic             frame_stb_q, frame_stb_d;
    logic             code_err_q, code_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    lock_state_e      state_q, state_d;

    // ---------------------------------------------------------------
    // Input stage and settle detection
    // ---------------------------------------------------------------
    logic        w_changed;
    logic        w_sample;
    logic [10:0] w_norm;
    logic [3:0]  w_an_act;
    logic [6:0]  w_seg_act;

    // Comparing the two synchronizer stages detects the change on the same
    // edge it reaches sync2_q, so stable_cnt counts cycles sync2_q has held.
    assign w_changed = (sync1_q != sync2_q);
    assign w_sample  = !w_changed && (stable_cnt_q == CNT_FIRE);
    assign w_norm    = ACTIVE_LOW ? ~sync2_q : sync2_q;
    assign w_an_act  = w_norm[10:7];
    assign w_seg_act = w_norm[6:0];

    always_comb begin
        stable_cnt_d = stable_cnt_q;
        if (w_changed) begin
            stable_cnt_d = '0;
        end else if (stable_cnt_q != CNT_MAX) begin
            stable_cnt_d = stable_cnt_q + CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Sample classification
    // ---------------------------------------------------------------
    logic       w_dec_legal, w_dec_blank;
    logic [3:0] w_dec_nibble;
    logic       w_one_hot, w_multi;
    logic [1:0] w_idx;

    seg7_pattern_decode u_decode (
        .seg_i    (w_seg_act),
        .legal_o  (w_dec_legal),
        .blank_o  (w_dec_blank),
        .nibble_o (w_dec_nibble)
    );

    always_comb begin
        w_one_hot = 1'b0;
        w_multi   = 1'b0;
        w_idx     = 2'd0;
        case (w_an_act)
            4'b0000: ;
            4'b0001: begin w_one_hot = 1'b1; w_idx = 2'd0; end
            4'b0010: begin w_one_hot = 1'b1; w_idx = 2'd1; end
            4'b0100: begin w_one_hot = 1'b1; w_idx = 2'd2; end
            4'b1000: begin w_one_hot = 1'b1; w_idx = 2'd3; end
            default: w_multi = 1'b1;
        endcase
    end

    logic w_capture, w_illegal;
    assign w_capture = w_sample && w_one_hot && w_dec_legal;
    assign w_illegal = w_sample && (w_multi || (w_one_hot && !w_dec_legal));

    // ---------------------------------------------------------------
    // Frame assembly, error accounting, timeout and lock state
    // ---------------------------------------------------------------
    logic w_timeout;

    always_comb begin
        shadow_d       = shadow_q;
        shadow_blank_d = shadow_blank_q;
        mask_d         = mask_q;
        digits_d       = digits_q;
        blank_d        = blank_q;
        frame_stb_d    = 1'b0;
        code_err_d     = 1'b0;
        err_cnt_d      = err_cnt_q;
        to_cnt_d       = to_cnt_q;
        state_d        = state_q;
        w_timeout      = 1'b0;

        if (to_cnt_q != '0) begin
            to_cnt_d  = to_cnt_q - TO_W'(1);
            w_timeout = (to_cnt_q == TO_W'(1));
        end

        // Completion is one clock after the capture that filled the mask;
        // samples are at least two cycles apart so no capture overlaps it.
        if (mask_q == 4'hF) begin
            digits_d    = shadow_q;
            blank_d     = shadow_blank_q;
            frame_stb_d = 1'b1;
            mask_d      = 4'h0;
            state_d     = LOCKED;
        end

        if (w_timeout) begin
            mask_d  = 4'h0;
            state_d = IDLE;
        end

        if (w_illegal) begin
            code_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
            mask_d = 4'h0;
        end

        // A capture overrides a coincident timeout: the mask keeps its
        // contents and the lock state is unchanged.
        if (w_capture) begin
            shadow_d[4*w_idx +: 4] = w_dec_blank ? 4'h0 : w_dec_nibble;
            shadow_blank_d[w_idx]  = w_dec_blank;
            mask_d                 = mask_q;
            mask_d[w_idx]          = 1'b1;
            to_cnt_d               = TO_LOAD;
            state_d                = state_q;
        end
    end

    always_ff @(posedge clk_in or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_in or negedge RESET) begin
        if (!RESET) begin
            sync1_q        <= RAW_IDLE;
            sync2_q        <= RAW_IDLE;
            stable_cnt_q   <= '0;
            shadow_q       <= 16'h0000;
            shadow_blank_q <= 4'hF;
            mask_q         <= 4'h0;
            digits_q       <= 16'h0000;
            blank_q        <= 4'hF;
            frame_stb_q    <= 1'b0;
            code_err_q     <= 1'b0;
            err_cnt_q      <= 8'h00;
            to_cnt_q       <= '0;
        end else begin
            sync1_q        <= {anode, segs};
            sync2_q        <= sync1_q;
            stable_cnt_q   <= stable_cnt_d;
            shadow_q       <= shadow_d;
            shadow_blank_q <= shadow_blank_d;
            mask_q         <= mask_d;
            digits_q       <= digits_d;
            blank_q        <= blank_d;
            frame_stb_q    <= frame_stb_d;
            code_err_q     <= code_err_d;
            err_cnt_q      <= err_cnt_d;
            to_cnt_q       <= to_cnt_d;
        end
    end

    assign digits      = digits_q;
    assign blank       = blank_q;
    assign frame_valid = (state_q == LOCKED);
    assign frame_stb   = frame_stb_q;
    assign code_err    = code_err_q;
    assign err_cnt     = err_cnt_q;

endmodule : seg7_scan_decoder
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_decoder
//  Purpose  : Self-checking bench for seg7_scan_decoder. Stimulus is a
//             sequence of held pin values; a run-level reference model
//             predicts frames and error pulses into queues that a monitor
//             drains whenever the DUT strobes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_decoder;

    localparam int S = 4;
    localparam int T = 100;

    logic        clk_in = 1'b0;
    logic        RESET;
    logic [3:0]  anode;
    logic [6:0]  segs;
    logic [15:0] digits;
    logic [3:0]  blank;
    logic        frame_valid, frame_stb, code_err;
    logic [7:0]  err_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_frames = 0;
    int last_stb_cyc = 0;

    seg7_scan_decoder #(
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk_in      (clk_in),
        .RESET       (RESET),
        .anode       (anode),
        .segs        (segs),
        .digits      (digits),
        .blank       (blank),
        .frame_valid (frame_valid),
        .frame_stb   (frame_stb),
        .code_err    (code_err),
        .err_cnt     (err_cnt)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model (active-high glyph table, run-based sampling)
    // ---------------------------------------------------------------
    logic [6:0]  glyph [16];
    logic [15:0] m_shadow;
    logic [3:0]  m_sblank;
    logic [3:0]  m_mask;
    int          m_errs;
    int          m_last_cap;
    bit          m_have_cap;
    logic [19:0] fq[$];   // {blank, digits}
    int          eq[$];   // expected err_cnt at each code_err

    logic [10:0] cur_pins;
    int          cur_start;
    bit          cur_sampled;

    task automatic model_reset();
        m_shadow = 16'h0; m_sblank = 4'hF; m_mask = 4'h0;
        m_errs = 0; m_last_cap = 0; m_have_cap = 0;
    endtask

    // One sample of a pin value that stayed put long enough; t is the clock
    // edge on which the decoder acts on it.
    task automatic model_sample(input logic [10:0] pins, input int t);
        logic [3:0] act_an;
        logic [6:0] act_sg;
        int  idx, nib;
        bit  ok, blk;
        act_an = ~pins[10:7];
        act_sg = ~pins[6:0];
        if (m_have_cap && (t - m_last_cap) > T) m_mask = 4'h0;
        if (act_an == 4'h0) return;
        ok = 0; blk = 0; nib = 0; idx = 0;
        if ($countones(act_an) == 1) begin
            for (int i = 0; i < 4; i++) if (act_an[i]) idx = i;
            if (act_sg == 7'h00) begin
                ok = 1; blk = 1;
            end else begin
                for (int g = 0; g < 16; g++) if (glyph[g] == act_sg) begin ok = 1; nib = g; end
            end
        end
        if (!ok) begin
            if (m_errs < 255) m_errs++;
            eq.push_back(m_errs);
            m_mask = 4'h0;
        end else begin
            m_shadow[4*idx +: 4] = 4'(nib);
            m_sblank[idx] = blk;
            m_mask[idx] = 1'b1;
            m_last_cap = t;
            m_have_cap = 1;
            if (m_mask == 4'hF) begin
                fq.push_back({m_sblank, m_shadow});
                m_mask = 4'h0;
            end
        end
    endtask

    // Hold pins for 'hold' clock edges. Equal consecutive values form one run.
    task automatic drive(input logic [3:0] an, input logic [6:0] sg, input int hold);
        @(negedge clk_in);
        if ({an, sg} != cur_pins) begin
            cur_pins = {an, sg}; cur_start = cyc; cur_sampled = 0;
        end
        anode = an; segs = sg;
        if (!cur_sampled && (cyc + hold - cur_start) >= S + 1) begin
            cur_sampled = 1;
            model_sample(cur_pins, cur_start + S + 2);
        end
        repeat (hold - 1) @(negedge clk_in);
    endtask

    function automatic logic [3:0] an_pin(input int i);
        logic [3:0] a;
        a = 4'hF;
        a[i] = 1'b0;
        return a;
    endfunction

    function automatic logic [6:0] seg_pin(input int n);
        return ~glyph[n];
    endfunction

    task automatic scan(input logic [15:0] val, input int hold);
        for (int i = 3; i >= 0; i--) drive(an_pin(i), seg_pin(int'(val[4*i +: 4])), hold);
    endtask

    task automatic idle(input int n);
        drive(4'hF, 7'h7F, n);
    endtask

    // ---------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------
    initial begin
        logic [19:0] f;
        forever begin
            @(negedge clk_in);
            if (RESET === 1'b1) begin
                if (frame_stb) begin
                    n_frames++;
                    last_stb_cyc = cyc;
                    if (fq.size() == 0) begin
                        check("frame_unexpected", 32'(frame_stb), 32'd0);
                    end else begin
                        f = fq.pop_front();
                        check("frame_digits", 32'(digits), 32'(f[15:0]));
                        check("frame_blank", 32'(blank), 32'(f[19:16]));
                        check("frame_valid_at_stb", 32'(frame_valid), 32'd1);
                    end
                end
                if (code_err) begin
                    if (eq.size() == 0) check("code_err_unexpected", 32'(code_err), 32'd0);
                    else check("err_cnt", 32'(err_cnt), 32'(eq.pop_front()));
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_digits"}, 32'(digits), 32'h0000);
        check({tag, "_blank"}, 32'(blank), 32'hF);
        check({tag, "_frame_valid"}, 32'(frame_valid), 32'd0);
        check({tag, "_frame_stb"}, 32'(frame_stb), 32'd0);
        check({tag, "_code_err"}, 32'(code_err), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    endtask

    task automatic release_reset();
        anode = 4'hF; segs = 7'h7F;
        repeat (3) @(negedge clk_in);
        RESET = 1'b1;
        cur_pins = 11'h7FF; cur_start = cyc; cur_sampled = 1;
    endtask

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    initial begin
        int f0, c_last, r, got, fall_cyc;
        logic [3:0] an;
        logic [6:0] sg;

        glyph[0]  = 7'h3F; glyph[1]  = 7'h06; glyph[2]  = 7'h5B; glyph[3]  = 7'h4F;
        glyph[4]  = 7'h66; glyph[5]  = 7'h6D; glyph[6]  = 7'h7D; glyph[7]  = 7'h07;
        glyph[8]  = 7'h7F; glyph[9]  = 7'h6F; glyph[10] = 7'h77; glyph[11] = 7'h7C;
        glyph[12] = 7'h39; glyph[13] = 7'h5E; glyph[14] = 7'h79; glyph[15] = 7'h71;

        RESET = 1'b0; anode = 4'hF; segs = 7'h7F;
        model_reset();
        repeat (2) @(negedge clk_in);
        check_reset_values("por");
        release_reset();
        idle(4);

        // Nominal scan of 1234 with the documented pin patterns
        f0 = n_frames;
        drive(4'b0111, 7'b1111001, 8);
        drive(4'b1011, 7'b0100100, 8);
        drive(4'b1101, 7'b0110000, 8);
        drive(4'b1110, 7'b0011001, 8);
        c_last = cur_start;
        idle(10);
        check("nominal_frame_count", 32'(n_frames - f0), 32'd1);
        check("nominal_latency", 32'(last_stb_cyc), 32'(c_last + S + 3));
        check("nominal_digits", 32'(digits), 32'h1234);
        check("nominal_blank", 32'(blank), 32'h0);
        check("nominal_frame_valid", 32'(frame_valid), 32'd1);

        // Short glitch to a "0" glyph mid-digit is not captured
        f0 = n_frames;
        drive(an_pin(3), seg_pin(1), 8);
        drive(an_pin(2), seg_pin(2), 3);
        drive(an_pin(2), 7'b1000000, 2);
        drive(an_pin(2), seg_pin(2), 8);
        drive(an_pin(1), seg_pin(3), 8);
        drive(an_pin(0), seg_pin(4), 8);
        idle(10);
        check("glitch_frame_count", 32'(n_frames - f0), 32'd1);
        check("glitch_digits", 32'(digits), 32'h1234);

        // Blank leftmost digit
        f0 = n_frames;
        drive(an_pin(3), 7'h7F, 8);
        drive(an_pin(2), seg_pin(2), 8);
        drive(an_pin(1), seg_pin(3), 8);
        drive(an_pin(0), seg_pin(4), 8);
        idle(10);
        check("blank_frame_count", 32'(n_frames - f0), 32'd1);
        check("blank_flags", 32'(blank), 32'h8);
        check("blank_digits", 32'(digits), 32'h0234);

        // Randomized scan traffic
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 99);
            if (r < 75)      an = an_pin($urandom_range(0, 3));
            else if (r < 85) an = 4'hF;
            else             an = 4'($urandom);
            r = $urandom_range(0, 99);
            if (r < 80)      sg = seg_pin($urandom_range(0, 15));
            else if (r < 88) sg = 7'h7F;
            else             sg = 7'($urandom);
            drive(an, sg, $urandom_range(1, 10));
        end
        idle(20);

        // Reset in the middle of a frame
        scan(16'hABCD, 8);
        drive(an_pin(3), seg_pin(5), 8);
        drive(an_pin(2), seg_pin(6), 8);
        check("prereset_digits", 32'(digits), 32'hABCD);
        check("prereset_frame_valid", 32'(frame_valid), 32'd1);
        check("prereset_fq_empty", 32'(fq.size()), 32'd0);
        check("prereset_eq_empty", 32'(eq.size()), 32'd0);
        @(posedge clk_in);
        #2 RESET = 1'b0;
        #1 check_reset_values("midreset");
        fq.delete(); eq.delete();
        model_reset();
        release_reset();
        f0 = n_frames;
        drive(an_pin(1), seg_pin(7), 8);
        drive(an_pin(0), seg_pin(8), 8);
        idle(10);
        check("postreset_partial_no_frame", 32'(n_frames - f0), 32'd0);
        drive(an_pin(3), seg_pin(9), 8);
        drive(an_pin(2), seg_pin(10), 8);
        idle(10);
        check("postreset_frame_count", 32'(n_frames - f0), 32'd1);
        check("postreset_digits", 32'(digits), 32'h9A78);

        // Illegal glyph and illegal anode patterns
        f0 = n_frames;
        drive(an_pin(3), seg_pin(1), 8);
        drive(an_pin(2), seg_pin(2), 8);
        drive(an_pin(1), seg_pin(3), 8);
        drive(an_pin(0), 7'b1111110, 8);
        idle(10);
        check("illegal_glyph_err_cnt", 32'(err_cnt), 32'd1);
        drive(an_pin(0), seg_pin(4), 8);
        idle(10);
        check("illegal_no_frame", 32'(n_frames - f0), 32'd0);
        drive(4'b0011, seg_pin(5), 8);
        idle(10);
        check("illegal_anode_err_cnt", 32'(err_cnt), 32'd2);
        for (int k = 0; k < 150; k++) begin
            drive(4'b0011, seg_pin(1), 6);
            drive(4'b0101, seg_pin(1), 6);
        end
        idle(10);
        check("err_cnt_saturated", 32'(err_cnt), 32'd255);

        // Timeout after the last capture
        scan(16'h1234, 8);
        idle(1);
        check("timeout_pre_valid", 32'(frame_valid), 32'd1);
        got = 0; fall_cyc = 0;
        for (int k = 0; k < 4 * T; k++) begin
            @(negedge clk_in);
            if (!frame_valid) begin got = 1; fall_cyc = cyc; break; end
        end
        check("timeout_seen", 32'(got), 32'd1);
        check("timeout_cycle", 32'(fall_cyc), 32'(m_last_cap + T));
        check("timeout_digits_hold", 32'(digits), 32'h1234);

        idle(20);
        check("end_fq_empty", 32'(fq.size()), 32'd0);
        check("end_eq_empty", 32'(eq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_seg7_scan_decoder
`default_nettype wire
